// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath widths, ALU function codes,
// operand-source selects, forwarding selects and the ID/EX register bundle.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_t;

  typedef enum logic {SRCA_RS1, SRCA_PC} srca_sel_t;
  typedef enum logic {SRCB_RS2, SRCB_IMM} srcb_sel_t;
  typedef enum logic [1:0] {FWD_REG, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;

  // Everything held in the ID/EX pipeline register. All-zero is the bubble.
  typedef struct packed {
    logic            valid;
    alu_fun_t        alu_fun;
    srca_sel_t       srca_sel;
    srcb_sel_t       srcb_sel;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rd_addr;
    logic            reg_write;
    logic            mem_read;
  } ex_regs_t;

  // True when a writeback stage targets the given source register (x0 excluded).
  function automatic logic rd_hit(logic we, logic [RA_W-1:0] rd, logic [RA_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand bypass selector for one source register.
// Ports: rs_addr/rs_data (stored operand), exmem_*/memwb_* (bypass sources),
// sel (which source won), data (selected operand). EX/MEM beats MEM/WB.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output fwd_sel_t        sel,
  output logic [XLEN-1:0] data
);

  always_comb begin
    sel  = FWD_REG;
    data = rs_data;
    if (rd_hit(exmem_reg_write, exmem_rd_addr, rs_addr)) begin
      sel  = FWD_EXMEM;
      data = exmem_result;
    end else if (rd_hit(memwb_reg_write, memwb_rd_addr, rs_addr)) begin
      sel  = FWD_MEMWB;
      data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding in front of the ALU.
// Ports: clk/rst_n (sync active-low reset); id_* decoded instruction;
// stall/flush pipeline control; exmem_*/memwb_* bypass sources;
// ex_* registered fields and ALU operands; load_use_stall hazard request.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned RA_W = riscv_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_fun,
  input  logic            id_srca_sel,
  input  logic            id_srcb_sel,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_fun,
  output logic [XLEN-1:0] ex_srca,
  output logic [XLEN-1:0] ex_srcb,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            load_use_stall
);

  ex_regs_t ex_d, ex_q;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      // A producer may retire from MEM/WB while we hold; capture its result so
      // the held operand is still correct once the bypass is gone.
      if (ex_q.valid) begin
        if (rd_hit(memwb_reg_write, memwb_rd_addr, ex_q.rs1_addr)) begin
          ex_d.rs1_data = memwb_result;
        end
        if (rd_hit(memwb_reg_write, memwb_rd_addr, ex_q.rs2_addr)) begin
          ex_d.rs2_data = memwb_result;
        end
      end
    end else begin
      ex_d.valid     = id_valid;
      ex_d.alu_fun   = alu_fun_t'(id_alu_fun);
      ex_d.srca_sel  = srca_sel_t'(id_srca_sel);
      ex_d.srcb_sel  = srcb_sel_t'(id_srcb_sel);
      ex_d.pc        = id_pc;
      ex_d.rs1_addr  = id_rs1_addr;
      ex_d.rs2_addr  = id_rs2_addr;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.imm       = id_imm;
      ex_d.rd_addr   = id_rd_addr;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_sel_t        rs1_sel, rs2_sel;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  fwd_mux u_fwd_rs1 (
    .rs_addr         (ex_q.rs1_addr),
    .rs_data         (ex_q.rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .sel             (rs1_sel),
    .data            (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .rs_addr         (ex_q.rs2_addr),
    .rs_data         (ex_q.rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .sel             (rs2_sel),
    .data            (fwd_rs2)
  );

  always_comb begin
    ex_valid      = ex_q.valid;
    ex_alu_fun    = ex_q.alu_fun;
    ex_pc         = ex_q.pc;
    ex_rd_addr    = ex_q.rd_addr;
    ex_reg_write  = ex_q.valid & ex_q.reg_write;
    ex_mem_read   = ex_q.valid & ex_q.mem_read;
    ex_srca       = (ex_q.srca_sel == SRCA_PC) ? ex_q.pc : fwd_rs1;
    ex_srcb       = (ex_q.srcb_sel == SRCB_IMM) ? ex_q.imm : fwd_rs2;
    ex_store_data = fwd_rs2;
    // Conservative: flags the hazard even if the ID instruction ignores the operand.
    load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) & id_valid &
                     ((ex_q.rd_addr == id_rs1_addr) | (ex_q.rd_addr == id_rs2_addr));
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_fun;
  logic        id_srca_sel, id_srcb_sel, id_reg_write, id_mem_read;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  logic [3:0]  ex_alu_fun;
  logic [31:0] ex_srca, ex_srcb, ex_store_data, ex_pc;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_alu_fun      (id_alu_fun),
    .id_srca_sel     (id_srca_sel),
    .id_srcb_sel     (id_srcb_sel),
    .id_rd_addr      (id_rd_addr),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .stall           (stall),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .ex_valid        (ex_valid),
    .ex_alu_fun      (ex_alu_fun),
    .ex_srca         (ex_srca),
    .ex_srcb         (ex_srcb),
    .ex_store_data   (ex_store_data),
    .ex_pc           (ex_pc),
    .ex_rd_addr      (ex_rd_addr),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .load_use_stall  (load_use_stall)
  );

  // Model of the instruction sitting in EX.
  typedef struct {
    bit        valid, asel, bsel, we, ld;
    bit [3:0]  fun;
    bit [31:0] pc, d1, d2, imm;
    bit [4:0]  a1, a2, rd;
  } slot_t;

  slot_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] bypass(input bit [4:0] a, input bit [31:0] stored);
    if (exmem_reg_write && exmem_rd_addr != 0 && exmem_rd_addr == a) return exmem_result;
    if (memwb_reg_write && memwb_rd_addr != 0 && memwb_rd_addr == a) return memwb_result;
    return stored;
  endfunction

  task automatic model_clock();
    slot_t z;
    z = '{default: 0};
    if (!rst_n || flush) begin
      m = z;
    end else if (stall) begin
      if (m.valid && memwb_reg_write && memwb_rd_addr != 0) begin
        if (memwb_rd_addr == m.a1) m.d1 = memwb_result;
        if (memwb_rd_addr == m.a2) m.d2 = memwb_result;
      end
    end else begin
      m = '{valid: id_valid, asel: id_srca_sel, bsel: id_srcb_sel, we: id_reg_write,
            ld: id_mem_read, fun: id_alu_fun, pc: id_pc, d1: id_rs1_data,
            d2: id_rs2_data, imm: id_imm, a1: id_rs1_addr, a2: id_rs2_addr,
            rd: id_rd_addr};
    end
  endtask

  task automatic compare_model();
    bit [31:0] f1, f2;
    bit        lu;
    f1 = bypass(m.a1, m.d1);
    f2 = bypass(m.a2, m.d2);
    lu = m.valid && m.ld && m.rd != 0 && id_valid && (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
    check("m_valid", 32'(ex_valid), 32'(m.valid));
    check("m_fun", 32'(ex_alu_fun), 32'(m.fun));
    check("m_pc", ex_pc, m.pc);
    check("m_rd", 32'(ex_rd_addr), 32'(m.rd));
    check("m_we", 32'(ex_reg_write), 32'(m.valid && m.we));
    check("m_ld", 32'(ex_mem_read), 32'(m.valid && m.ld));
    check("m_srca", ex_srca, m.asel ? m.pc : f1);
    check("m_srcb", ex_srcb, m.bsel ? m.imm : f2);
    check("m_store", ex_store_data, f2);
    check("m_lu", 32'(load_use_stall), 32'(lu));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0;
    id_rs2_data = 0; id_imm = 0; id_alu_fun = 0; id_srca_sel = 0; id_srcb_sel = 0;
    id_rd_addr = 0; id_reg_write = 0; id_mem_read = 0; stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
  endtask

  initial begin
    m = '{default: 0};
    idle_inputs();
    rst_n = 0;
    step(); step();
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_fun", 32'(ex_alu_fun), 0);
    check("rst_srca", ex_srca, 0);
    check("rst_srcb", ex_srcb, 0);

    // Capture latency.
    rst_n = 1; id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2;
    id_rs1_data = 5; id_imm = 7; id_srcb_sel = 1; id_pc = 32'h100;
    step();
    check("cap_srca", ex_srca, 5);
    check("cap_srcb", ex_srcb, 7);
    check("cap_valid", 32'(ex_valid), 1);

    // Forwarding priority.
    id_rs1_addr = 3; id_rs1_data = 32'h99; id_srcb_sel = 0;
    step();
    exmem_reg_write = 1; exmem_rd_addr = 3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd_addr = 3; memwb_result = 32'h22;
    #1 check("fwd_exmem", ex_srca, 32'h11);
    exmem_reg_write = 0;
    #1 check("fwd_memwb", ex_srca, 32'h22);
    id_rs1_addr = 0; id_rs1_data = 32'h55;
    exmem_reg_write = 1; exmem_rd_addr = 0; memwb_rd_addr = 0;
    step();
    check("fwd_x0", ex_srca, 32'h55);
    idle_inputs();

    // Load-use hazard.
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 4;
    step();
    id_mem_read = 0; id_rs2_addr = 4;
    #1 check("lu_hit", 32'(load_use_stall), 1);
    id_rs2_addr = 5;
    #1 check("lu_miss", 32'(load_use_stall), 0);
    id_mem_read = 1; id_rd_addr = 0; id_rs2_addr = 0;
    step();
    check("lu_x0", 32'(load_use_stall), 0);
    idle_inputs();

    // Stall refresh: producer retires from MEM/WB mid-stall.
    id_valid = 1; id_rs1_addr = 6; id_rs1_data = 0;
    step();
    stall = 1; id_rs1_data = 32'h1234;
    step();
    memwb_reg_write = 1; memwb_rd_addr = 6; memwb_result = 32'hABCD;
    step();
    memwb_reg_write = 0;
    step();
    check("refresh", ex_srca, 32'hABCD);
    idle_inputs();

    // Stall holds, flush beats stall.
    id_valid = 1; id_reg_write = 1; id_alu_fun = 4'b1000; id_pc = 32'h200; id_rd_addr = 9;
    step();
    stall = 1; id_alu_fun = 4'b0111; id_pc = 32'h300; id_rd_addr = 10;
    step();
    check("hold_fun", 32'(ex_alu_fun), 8);
    check("hold_pc", ex_pc, 32'h200);
    check("hold_rd", 32'(ex_rd_addr), 9);
    flush = 1;
    step();
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_we", 32'(ex_reg_write), 0);
    check("flush_fun", 32'(ex_alu_fun), 0);
    idle_inputs();

    // Reset in the middle of a stall.
    id_valid = 1; id_mem_read = 1; id_rd_addr = 4; id_rs1_addr = 4; id_rs1_data = 32'h77;
    step();
    stall = 1; rst_n = 0;
    step();
    check("mrst_valid", 32'(ex_valid), 0);
    check("mrst_lu", 32'(load_use_stall), 0);
    check("mrst_srca", ex_srca, 0);
    rst_n = 1; idle_inputs();

    // Randomized traffic; small register range so hazards and bypasses collide.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      stall = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 10);
      id_valid = $urandom_range(0, 1);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_alu_fun = 4'($urandom); id_srca_sel = $urandom_range(0, 1);
      id_srcb_sel = $urandom_range(0, 1); id_reg_write = $urandom_range(0, 1);
      id_mem_read = $urandom_range(0, 1);
      exmem_reg_write = $urandom_range(0, 1); exmem_rd_addr = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_reg_write = $urandom_range(0, 1); memwb_rd_addr = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
